shading_rate_map_writer: RTL and testbench
==========================================

Name: shading_rate_map_writer

Overview:
- Producer side of the VRS shading rate map. Accepts rectangle-fill commands from the command processor and streams per-tile write beats into the map memory that the per-pixel rate lookup reads.
- The map memory holds one 4-bit word per tile, {rx[1:0], ry[1:0]}, in row-major order: addr = tile_y*MAP_W + tile_x.
- Sits between the command front-end and the map RAM write port. Handles map clears, region updates and error rejection.

Parameters:
- MAP_W, 64, map width in tiles
- MAP_H, 36, map height in tiles
- ADDR_W, 12, map address width; must satisfy 2^ADDR_W >= MAP_W*MAP_H

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_clear  in  1  1 = fill the whole map and ignore the coordinates
- cmd_x0  in  16  first tile column, inclusive
- cmd_y0  in  16  first tile row, inclusive
- cmd_x1  in  16  last tile column, inclusive
- cmd_y1  in  16  last tile row, inclusive
- cmd_rx  in  2  x rate code: 0=1, 1=2, 2=4, 3=reserved
- cmd_ry  in  2  y rate code, same encoding as cmd_rx
- mem_stall  in  1  map RAM cannot take a write this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  4  {rx, ry}
- busy  out  1  a fill is in progress
- done  out  1  one-cycle pulse when a fill completes
- err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset values (async, take effect immediately): state IDLE, cmd_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
- States are IDLE, FILL, DONE.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Command fields are sampled only in the accept cycle; they may change freely afterwards.
- Clear command: the region is x 0..MAP_W-1, y 0..MAP_H-1.
- Region command, clamping: x1 is clamped to MAP_W-1 and y1 to MAP_H-1.
- Region command, rejection: the command is rejected (no writes issued) if x0>x1, y0>y1, x0>=MAP_W, or y0>=MAP_H, with the comparisons made after clamping. It is also rejected if cmd_rx==3 or cmd_ry==3.
- Rejection timing: err=1 in the cycle after accept; the block stays in IDLE, so a new command can be accepted in that same cycle.
- IDLE→FILL on a valid accept.
  - Latch the region and the rate word.
  - Set row_base = y0*MAP_W, computed once at accept (a constant multiply is allowed there only).
  - Set x=x0, y=y0, busy=1.
- FILL, write beats:
  - Each cycle, mem_we=1, mem_addr=row_base+x, mem_wdata={rx,ry}.
  - A beat completes on a cycle with mem_we && !mem_stall.
  - While mem_stall=1, mem_we, mem_addr and mem_wdata are held stable and the counters do not advance.
- FILL, counter advance after a completed beat:
  - If x<x1: x increments.
  - Otherwise, if y<y1: x returns to x0, y increments, and row_base += MAP_W (addition only, no multiply).
  - Otherwise the state moves to DONE.
- DONE: mem_we=0, done=1 for exactly one cycle, busy=0, then IDLE.
- Latency and throughput:
  - First write appears the cycle after accept.
  - An N-tile region with no stalls takes N FILL cycles plus 1 DONE cycle.
  - Next accept is possible at the earliest 2 cycles after the last write.
- Width rules: x and y counters are 16 bits; row_base and mem_addr are ADDR_W bits; no overflow can occur once clamping is applied.
- Boundaries:
  - A single-tile region (x0==x1, y0==y1) produces exactly 1 beat.
  - A 1-wide column produces one beat per row.
  - Stall on the final beat delays DONE until that beat completes.
  - Reset mid-FILL aborts immediately: mem_we drops asynchronously and no done pulse is produced. Partially written tiles are left as written.
- done and err are never asserted in the same cycle.

Decomposition:
- Package vrs_pkg holds:
  - rate code constants: VRS_RATE_1=2'd0, VRS_RATE_2=2'd1, VRS_RATE_4=2'd2, VRS_RATE_RSVD=2'd3
  - the packed map word typedef {rx, ry}
  - the state enum
- Shared with the lookup side so that both ends use the same encoding.
- One sub-module is natural: srm_rect_walker, the x/y/row_base counter with advance, stall-hold and last-beat flag. Command validation and the FSM stay in the top.

Test Plan:
- Clear with rates (1,1) and no stall → 2304 beats; addr runs 0..2303 in order; wdata=4'b0101; done exactly 1 cycle after the last beat; busy low afterwards.
- Region x0=2, y0=3, x1=4, y1=4, rate (2,0) → 6 beats at addr 194, 195, 196, 258, 259, 260; wdata=4'b1000; then done.
- Same region with mem_stall=1 on the 2nd and 6th beats for 3 cycles each → mem_we, mem_addr and mem_wdata held stable throughout each stall; 6 beats total; done after the 6th beat completes.
- Invalid command checks, each giving err=1 one cycle after accept and mem_we never asserted:
  - x0=5, x1=3 → rejected.
  - cmd_rx=3 → rejected.
  - x0=70 → rejected.
  - x1=100 with x0=62, y0=y1=0 → clamped to 2 beats at addr 62, 63.
- Back-to-back commands with cmd_valid held high → second accept only in IDLE, no beat overlap; rejected-then-valid commands are accepted on consecutive cycles.
- Assert rst during beat 3 of a 6-beat fill → mem_we=0 immediately; no done pulse; cmd_ready=1 after release; the next command runs correctly.

Source files
------------

// File: rtl/vrs_pkg.sv
// Encoding shared by both ends of the VRS shading rate map: rate codes,
// the packed per-tile map word, and the writer FSM states.
package vrs_pkg;

  localparam logic [1:0] VRS_RATE_1    = 2'd0;
  localparam logic [1:0] VRS_RATE_2    = 2'd1;
  localparam logic [1:0] VRS_RATE_4    = 2'd2;
  localparam logic [1:0] VRS_RATE_RSVD = 2'd3;

  // One map word per tile; rx occupies the upper two bits.
  typedef struct packed {
    logic [1:0] rx;
    logic [1:0] ry;
  } vrs_map_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } srm_state_t;

endpackage

// File: rtl/srm_rect_walker.sv
// Row-major rectangle walker: holds x/y/row_base, steps once per completed
// beat, and flags the final tile of the region.
module srm_rect_walker #(
  parameter int MAP_W  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [15:0]       i_x0,
  input  logic [15:0]       i_y0,
  input  logic [15:0]       i_x1,
  input  logic [15:0]       i_y1,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [15:0]       r_x0;
  logic [15:0]       r_x1;
  logic [15:0]       r_y1;
  logic [ADDR_W-1:0] r_row_base;

  logic w_x_end;
  logic w_y_end;

  assign w_x_end = (r_x >= r_x1);
  assign w_y_end = (r_y >= r_y1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_x        <= i_x0;
      r_y        <= i_y0;
      r_x0       <= i_x0;
      r_x1       <= i_x1;
      r_y1       <= i_y1;
      // Only multiply in the walker; later rows are reached by adding MAP_W.
      r_row_base <= ADDR_W'(32'(i_y0) * 32'(MAP_W));
    end else if (i_advance) begin
      if (!w_x_end) begin
        r_x <= r_x + 16'd1;
      end else if (!w_y_end) begin
        r_x        <= r_x0;
        r_y        <= r_y + 16'd1;
        r_row_base <= r_row_base + ADDR_W'(MAP_W);
      end
    end
  end

  // x is already clamped below MAP_W, so truncating it to ADDR_W is lossless.
  assign o_addr = r_row_base + ADDR_W'(r_x);
  assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/shading_rate_map_writer.sv
// Producer side of the VRS shading rate map: validates rectangle-fill
// commands and streams one map-word write per tile into the map RAM.
module shading_rate_map_writer
  import vrs_pkg::*;
#(
  parameter int MAP_W  = 64,
  parameter int MAP_H  = 36,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [15:0]       cmd_x0,
  input  logic [15:0]       cmd_y0,
  input  logic [15:0]       cmd_x1,
  input  logic [15:0]       cmd_y1,
  input  logic [1:0]        cmd_rx,
  input  logic [1:0]        cmd_ry,
  input  logic              mem_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] X_MAX = 16'(MAP_W - 1);
  localparam logic [15:0] Y_MAX = 16'(MAP_H - 1);

  srm_state_t    r_state;
  srm_state_t    w_next_state;
  vrs_map_word_t r_word;
  logic          r_err;

  logic        w_accept;
  logic        w_start;
  logic        w_cmd_ok;
  logic        w_rate_ok;
  logic        w_beat;
  logic        w_last;
  logic [15:0] w_x0;
  logic [15:0] w_y0;
  logic [15:0] w_x1;
  logic [15:0] w_y1;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_start  = w_accept && w_cmd_ok;
  assign w_beat   = mem_we && !mem_stall;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned and infers a latch.
  always_comb begin
    w_x0 = cmd_x0;
    w_y0 = cmd_y0;
    w_x1 = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
    w_y1 = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
    if (cmd_clear) begin
      w_x0 = '0;
      w_y0 = '0;
      w_x1 = X_MAX;
      w_y1 = Y_MAX;
    end
  end

  // Bounds are checked against the clamped corner; a reserved rate code is
  // never written into the map.
  assign w_rate_ok = (cmd_rx != VRS_RATE_RSVD) && (cmd_ry != VRS_RATE_RSVD);
  assign w_cmd_ok  = w_rate_ok && (w_x0 <= w_x1) && (w_y0 <= w_y1) &&
                     (w_x0 <= X_MAX) && (w_y0 <= Y_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start)          w_next_state = ST_FILL;
      ST_FILL: if (w_beat && w_last) w_next_state = ST_DONE;
      ST_DONE:                       w_next_state = ST_IDLE;
      default:                       w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_FILL: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // A rejected command leaves the FSM in IDLE, so err is a registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept && !w_cmd_ok;
      if (w_start) begin
        r_word.rx <= cmd_rx;
        r_word.ry <= cmd_ry;
      end
    end
  end

  assign mem_wdata = r_word;
  assign err       = r_err;

  srm_rect_walker #(
    .MAP_W  (MAP_W),
    .ADDR_W (ADDR_W)
  ) u_walker (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_start),
    .i_x0      (w_x0),
    .i_y0      (w_y0),
    .i_x1      (w_x1),
    .i_y1      (w_y1),
    .i_advance (w_beat),
    .o_addr    (mem_addr),
    .o_last    (w_last)
  );

endmodule

// File: tb/tb_shading_rate_map_writer.sv
// Self-checking bench for shading_rate_map_writer: a tile-list model predicts
// every write beat and the done/err pulse cycles; directed tests pin literals.
module tb_shading_rate_map_writer;

  localparam int MAP_W  = 64;
  localparam int MAP_H  = 36;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_clear = 1'b0;
  logic [15:0]       cmd_x0 = '0;
  logic [15:0]       cmd_y0 = '0;
  logic [15:0]       cmd_x1 = '0;
  logic [15:0]       cmd_y1 = '0;
  logic [1:0]        cmd_rx = '0;
  logic [1:0]        cmd_ry = '0;
  logic              mem_stall = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  shading_rate_map_writer #(
    .MAP_W  (MAP_W),
    .MAP_H  (MAP_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_rx    (cmd_rx),
    .cmd_ry    (cmd_ry),
    .mem_stall (mem_stall),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } beat_t;

  beat_t exp_q[$];
  int    obs_addr[$];
  int    obs_data[$];
  int    n_checks      = 0;
  int    n_fail        = 0;
  int    cyc           = 0;
  int    done_due      = -1;
  int    err_due       = -1;
  int    last_beat_cyc = -1;
  int    region_lit[6] = '{194, 195, 196, 258, 259, 260};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: a command is either rejected (err next cycle) or becomes the
  // row-major list of tiles inside its clamped rectangle.
  task automatic model_cmd(input logic clr, input int x0, input int y0, input int x1,
                           input int y1, input int rx, input int ry, input int acc);
    int    xs, ys, xe, ye;
    bit    rej;
    beat_t b;
    if (clr) begin
      xs = 0; ys = 0; xe = MAP_W - 1; ye = MAP_H - 1;
    end else begin
      xs = x0; ys = y0;
      xe = (x1 > MAP_W - 1) ? MAP_W - 1 : x1;
      ye = (y1 > MAP_H - 1) ? MAP_H - 1 : y1;
    end
    rej = (rx == 3) || (ry == 3) || (xs > xe) || (ys > ye) || (xs >= MAP_W) || (ys >= MAP_H);
    if (rej) begin
      err_due = acc + 1;
    end else begin
      for (int y = ys; y <= ye; y++) begin
        for (int x = xs; x <= xe; x++) begin
          b.addr = y * MAP_W + x;
          b.data = rx * 4 + ry;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Present a command, hold it until accepted; returns at posedge+1 of the
  // cycle after the accept, with cmd_valid dropped.
  task automatic issue(input logic clr, input int x0, input int y0, input int x1,
                       input int y1, input int rx, input int ry, output int acc);
    int n;
    n = 0;
    cmd_clear = clr;
    cmd_x0    = 16'(x0);
    cmd_y0    = 16'(y0);
    cmd_x1    = 16'(x1);
    cmd_y1    = 16'(y1);
    cmd_rx    = 2'(rx);
    cmd_ry    = 2'(ry);
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("accept_within_budget", 32'(cmd_ready), 32'd1);
    acc = cyc;
    @(posedge clk);
    model_cmd(clr, x0, y0, x1, y1, rx, ry, acc);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready && exp_q.size() == 0 && done_due < cyc) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < 6000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  // Compare process: every FILL cycle against the model's next tile, and the
  // done/err/busy outputs on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'(mem_we), 32'd0);
        end else begin
          check("beat_addr", 32'(mem_addr), exp_q[0].addr);
          check("beat_data", 32'(mem_wdata), exp_q[0].data);
          if (!mem_stall) begin
            obs_addr.push_back(int'(mem_addr));
            obs_data.push_back(int'(mem_wdata));
            exp_q.delete(0);
            last_beat_cyc = cyc;
            if (exp_q.size() == 0) done_due = cyc + 1;
          end
        end
      end
      check("done_pulse", 32'(done), 32'(cyc == done_due));
      check("err_pulse", 32'(err), 32'(cyc == err_due));
      check("busy_tracks_fill", 32'(busy), 32'(mem_we));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, last1, bd, st, n;

    // Async reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-map clear, rates (1,1).
    clear_obs();
    issue(1'b1, 99, 99, 0, 0, 1, 1, acc);
    wait_idle();
    check("clear_beats", obs_addr.size(), 32'd2304);
    n = 0;
    for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] != i) n++;
    check("clear_addr_order", n, 32'd0);
    check("clear_wdata", obs_data[0], 32'b0101);
    check("clear_latency", last_beat_cyc - acc, 32'd2304);
    check("clear_busy_after", 32'(busy), 32'd0);

    // Region (2,3)-(4,4), rates (2,0).
    clear_obs();
    issue(1'b0, 2, 3, 4, 4, 2, 0, acc);
    wait_idle();
    check("region_beats", obs_addr.size(), 32'd6);
    for (int i = 0; i < 6 && i < obs_addr.size(); i++) check("region_addr", obs_addr[i], region_lit[i]);
    check("region_wdata", obs_data[0], 32'b1000);
    check("region_latency", last_beat_cyc - acc, 32'd6);

    // Same region, 2nd and 6th beats stalled for 3 cycles each.
    clear_obs();
    issue(1'b0, 2, 3, 4, 4, 2, 0, acc);
    bd = 0; st = 0; n = 0;
    while (bd < 6 && n < 100) begin
      if (mem_we) begin
        if ((bd == 1 || bd == 5) && st < 3) begin
          mem_stall = 1'b1;
          st++;
        end else begin
          mem_stall = 1'b0;
          bd++;
          st = 0;
        end
      end else begin
        mem_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    mem_stall = 1'b0;
    check("stall_loop_budget", 32'(n < 100), 32'd1);
    wait_idle();
    check("stall_beats", obs_addr.size(), 32'd6);
    for (int i = 0; i < 6 && i < obs_addr.size(); i++) check("stall_addr", obs_addr[i], region_lit[i]);
    check("stall_latency", last_beat_cyc - acc, 32'd12);

    // Rejections: no beats, err one cycle after accept (checked every cycle).
    clear_obs();
    issue(1'b0, 5, 0, 3, 0, 0, 0, acc);
    wait_idle();
    issue(1'b0, 0, 0, 1, 1, 3, 0, acc);
    wait_idle();
    issue(1'b0, 70, 0, 70, 0, 0, 0, acc);
    wait_idle();
    check("reject_no_beats", obs_addr.size(), 32'd0);

    // x1 beyond the map is clamped to the last column.
    clear_obs();
    issue(1'b0, 62, 0, 100, 0, 0, 0, acc);
    wait_idle();
    check("clamp_beats", obs_addr.size(), 32'd2);
    if (obs_addr.size() == 2) begin
      check("clamp_addr0", obs_addr[0], 32'd62);
      check("clamp_addr1", obs_addr[1], 32'd63);
    end

    // Back-to-back with cmd_valid continuously high; second is a 1-wide column.
    clear_obs();
    issue(1'b0, 0, 0, 1, 0, 0, 0, acc);
    issue(1'b0, 10, 1, 10, 3, 1, 2, acc2);
    last1 = last_beat_cyc;
    check("b2b_accept_gap", acc2 - last1, 32'd2);
    wait_idle();
    check("b2b_beats", obs_addr.size(), 32'd5);
    if (obs_addr.size() == 5) begin
      check("b2b_addr1", obs_addr[1], 32'd1);
      check("col_addr0", obs_addr[2], 32'd74);
      check("col_addr2", obs_addr[4], 32'd202);
      check("col_wdata", obs_data[2], 32'b0110);
    end

    // Rejected then valid single tile, accepted on consecutive cycles.
    clear_obs();
    issue(1'b0, 5, 0, 3, 0, 0, 0, acc);
    issue(1'b0, 63, 35, 63, 35, 2, 2, acc2);
    check("reject_then_accept_gap", acc2 - acc, 32'd1);
    wait_idle();
    check("single_beats", obs_addr.size(), 32'd1);
    if (obs_addr.size() == 1) begin
      check("single_addr", obs_addr[0], 32'd2303);
      check("single_wdata", obs_data[0], 32'b1010);
    end

    // Reset asserted while beat 3 of a 6-beat fill is on the bus.
    clear_obs();
    issue(1'b0, 2, 3, 4, 4, 1, 0, acc);
    n = 0;
    while (obs_addr.size() < 2 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #1;
    check("pre_reset_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("reset_drops_we", 32'(mem_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    exp_q.delete();
    done_due = -1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    clear_obs();
    issue(1'b0, 2, 3, 4, 4, 1, 0, acc);
    wait_idle();
    check("post_reset_beats", obs_addr.size(), 32'd6);
    for (int i = 0; i < 6 && i < obs_addr.size(); i++) check("post_reset_addr", obs_addr[i], region_lit[i]);
    if (obs_data.size() > 0) check("post_reset_wdata", obs_data[0], 32'b0100);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
